// File: rtl/sreg_tx.sv
`default_nettype none
// ============================================================================
// Module      : sreg_tx
// Description : Parallel-in / serial-out transmitter for the shift-register
//               link. Accepts a WIDTH-bit word through a load/ready handshake
//               and shifts it out MSB first, one bit per en cycle. A receiver
//               that samples data_out under the same en rebuilds the word
//               unchanged in its own shift register. One frame in flight.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      word width in bits, legal range 2..32
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active low
//   data_in    in   WIDTH  parallel word, sampled only when a load is accepted
//   load       in   1      request to start a frame with data_in
//   ready      out  1      load is accepted this cycle
//   en         in   1      shift enable, each en=1 edge in a frame consumes a bit
//   data_out   out  1      serial bit, MSB first, 0 outside a frame
//   out_valid  out  1      data_out carries a frame bit
//   done       out  1      one-cycle pulse as the block re-enters IDLE
// Configuration
//   SREG_TX_PARITY_EN  when defined, an even-parity bit (XOR of the loaded
//                      word) is appended after the last data bit.
// ============================================================================
module sreg_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             data_out,
    output logic             out_valid,
    output logic             done
);

    // Bit counter holds the number of data bits still to be consumed; it
    // must represent WIDTH itself, hence the +1.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef SREG_TX_PARITY_EN
        ,
        S_PAR   = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q,  done_d;
`ifdef SREG_TX_PARITY_EN
    // Parity is captured at load time so later data_in changes cannot
    // disturb the bit that closes the frame.
    logic             par_q,   par_d;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef SREG_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef SREG_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        done_d    = 1'b0;
`ifdef SREG_TX_PARITY_EN
        par_d     = par_q;
`endif
        ready     = 1'b0;
        out_valid = 1'b0;
        data_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // en is deliberately ignored here: a load/en collision only
                // starts the frame, it never consumes the first bit.
                ready = 1'b1;
                if (load) begin
                    shift_d = data_in;
                    count_d = CW'(WIDTH);
                    state_d = S_SHIFT;
`ifdef SREG_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end

            S_SHIFT: begin
                out_valid = 1'b1;
                data_out  = shift_q[WIDTH-1];
                if (en) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
`ifdef SREG_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end

`ifdef SREG_TX_PARITY_EN
            S_PAR: begin
                out_valid = 1'b1;
                data_out  = par_q;
                if (en) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // done is registered so it lines up with the first IDLE cycle, the same
    // cycle in which ready returns high for a back-to-back load.
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sreg_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sreg_tx
// Description : Self-checking bench for sreg_tx. Every accepted load pushes
//               the expected serial bits onto a scoreboard queue; each bit is
//               popped when the bench consumes it with en. A loopback
//               receiver rebuilds each frame and is compared on done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sreg_tx;

    localparam int W = 4;
`ifdef SREG_TX_PARITY_EN
    localparam int FL = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load;
    logic         ready;
    logic         en;
    logic         data_out;
    logic         out_valid;
    logic         done;

    sreg_tx #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .en        (en),
        .data_out  (data_out),
        .out_valid (out_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } bit_t;

    bit_t          bq[$];   // expected serial bits
    logic [FL-1:0] fq[$];   // expected frame as seen by the receiver
    logic [FL-1:0] rx;      // loopback receiver shift register
    logic          exp_done;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ready",     64'(ready),     64'(bq.size() == 0));
        check("out_valid", 64'(out_valid), 64'(bq.size() != 0));
        check("data_out",  64'(data_out),  64'((bq.size() != 0) ? bq[0].b : 1'b0));
        check("done",      64'(done),      64'(exp_done));
    endtask

    // One clock cycle: drive inputs at the falling edge, update the model
    // across the rising edge, compare at the next falling edge.
    task automatic step(input logic ld, input logic [W-1:0] d, input logic e);
        logic          acc;
        logic          con;
        logic          lst;
        logic [FL-1:0] rx_n;
        logic [FL-1:0] frm;
        bit_t          nb;
        load    = ld;
        data_in = d;
        en      = e;
        acc  = ld && (bq.size() == 0);
        con  = e && (bq.size() != 0);
        rx_n = rx;
        if (e && out_valid) rx_n = {rx[FL-2:0], data_out};
        @(posedge clk);
        rx       = rx_n;
        exp_done = 1'b0;
        if (con) begin
            lst = bq[0].last;
            void'(bq.pop_front());
            if (lst) exp_done = 1'b1;
        end
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) begin
                nb.b    = d[i];
                nb.last = (i == 0) && !PAR;
                bq.push_back(nb);
            end
            if (PAR) begin
                nb.b    = ^d;
                nb.last = 1'b1;
                bq.push_back(nb);
                frm = FL'({d, ^d});
            end else begin
                frm = FL'(d);
            end
            fq.push_back(frm);
        end
        @(negedge clk);
        check_outputs();
        if (exp_done) begin
            if (fq.size() != 0) check("loopback", 64'(rx), 64'(fq.pop_front()));
            else check("loopback_frame", 64'(0), 64'(1));
        end
    endtask

    // Assert reset between clock edges mid-frame; outputs must clear at once.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        bq.delete();
        fq.delete();
        rx       = '0;
        exp_done = 1'b0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
    endtask

    task automatic send_stream(input logic [W-1:0] d);
        step(1'b1, d, 1'b1);
        for (int i = 0; i < FL; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        logic         pat[7];
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        load     = 1'b0;
        en       = 1'b0;
        data_in  = '0;
        rx       = '0;
        exp_done = 1'b0;
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Held in reset: load/en toggling must have no effect.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            load    = i[0];
            en      = i[1];
            data_in = 4'hF;
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b1;
        step(1'b0, '0, 1'b0);

        // Continuous en.
        send_stream(4'b1011);
        send_stream(4'b1001);

        // Stalls between consumed bits.
        step(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, pat[i]);
        if (PAR) begin
            step(1'b0, '0, 1'b0);
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);

        // Loads during a frame are ignored; a load in the done cycle is taken.
        step(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < FL - 1; i++) step(1'b1, 4'b1111, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 4'b0110, 1'b1);
        for (int i = 0; i < FL; i++) step(1'b0, 4'b1111, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset after two bits; the following frame must be clean.
        step(1'b1, 4'b1100, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        async_reset();
        send_stream(4'b0101);

        // Random traffic with random enable.
        for (int i = 0; i < 120; i++) begin
            w = W'($urandom);
            step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 2 * FL; i++) step(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
